intr_ctrl: RTL

Interrupt controller sitting between the 32 interrupt-cause sources and the microprogram sequencer. Latches cause pulses into a pending register, applies a mask, selects the lowest-numbered pending unmasked cause and presents its microcode entry address, taken from a 32-entry vector table, to the sequencer through a request/acknowledge handshake. Tracks one in-service interrupt until the microcode signals end of interrupt.

---
 rtl/intr_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/intr_ctrl.sv
// Interrupt controller: pending/mask registers, lowest-index priority select and a
// req/ack handshake to the microsequencer. `define INTR_VECTAB_EN for a writable vector table.
module intr_ctrl #(
    parameter int NINTR    = 32,
    parameter int VECW     = 12,
    parameter int VEC_BASE = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NINTR-1:0]         irq_set,
    input  logic                     clr_we,
    input  logic [$clog2(NINTR)-1:0] clr_idx,
    input  logic                     mask_we,
    input  logic [NINTR-1:0]         mask_wdata,
    input  logic                     tab_we,
    input  logic [$clog2(NINTR)-1:0] tab_idx,
    input  logic [VECW-1:0]          tab_wdata,
    input  logic                     intr_en,
    input  logic                     ack,
    input  logic                     eoi,
    output logic                     req,
    output logic [VECW-1:0]          vector,
    output logic [$clog2(NINTR)-1:0] num,
    output logic                     in_service,
    output logic [NINTR-1:0]         pending,
    output logic [NINTR-1:0]         mask,
    output logic [1:0]               fsm_state
);

    localparam int IW = $clog2(NINTR);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARB  = 2'd1;
    localparam logic [1:0] S_REQ  = 2'd2;
    localparam logic [1:0] S_SERV = 2'd3;

    // Handshake: req stays high with num/vector frozen until the cycle ack is
    // sampled high; that edge clears pending[num] and enters service.

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [NINTR-1:0] clr_vec;
    logic [NINTR-1:0] ack_vec;
    logic [NINTR-1:0] pending_nxt;
    logic [NINTR-1:0] eligible;
    logic             any_nxt;
    logic             win_found;
    logic [IW-1:0]    win_idx;
    logic [VECW-1:0]  vec_sel;
    logic             num_cleared;

    always_comb begin
        clr_vec = '0;
        ack_vec = '0;
        if (clr_we) clr_vec[clr_idx] = 1'b1;
        if (state == S_REQ && ack) ack_vec[num] = 1'b1;
        // A new pulse always wins over any clear of the same bit.
        pending_nxt = ((pending | irq_set) & ~clr_vec & ~ack_vec) | irq_set;
    end

    assign eligible = pending & mask;
    // IDLE looks at the incoming pulses too, so a pulse reaches REQ two edges later.
    assign any_nxt  = |(pending_nxt & mask);

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = NINTR - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_found = 1'b1;
                win_idx   = IW'(i);
            end
        end
    end

`ifdef INTR_VECTAB_EN
    logic [VECW-1:0] vec_tab [NINTR];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NINTR; i++) vec_tab[i] <= '0;
        end else if (tab_we) begin
            vec_tab[tab_idx] <= tab_wdata;
        end
    end

    assign vec_sel = vec_tab[win_idx];
`else
    logic unused_tab;
    assign unused_tab = &{1'b0, tab_we, tab_idx, tab_wdata};
    assign vec_sel    = VECW'(VEC_BASE) + VECW'(win_idx);
`endif

    assign num_cleared = clr_we && (clr_idx == num);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (intr_en && any_nxt) state_nxt = S_ARB;
            S_ARB: begin
                if (!intr_en || !win_found) state_nxt = S_IDLE;
                else                        state_nxt = S_REQ;
            end
            S_REQ: begin
                if (ack)                               state_nxt = S_SERV;
                else if (!intr_en || num_cleared)      state_nxt = S_IDLE;
            end
            S_SERV: if (eoi) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            pending <= '0;
            mask    <= '0;
            num     <= '0;
            vector  <= '0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            if (mask_we) mask <= mask_wdata;
            // num/vector only load on the way into REQ, so they hold through it.
            if (state == S_ARB && state_nxt == S_REQ) begin
                num    <= win_idx;
                vector <= vec_sel;
            end
        end
    end

    assign req        = (state == S_REQ);
    assign in_service = (state == S_SERV);
    assign fsm_state  = state;

endmodule
